stream_arbiter_burst: RTL and testbench
=======================================

Name: stream_arbiter_burst

Overview:
- Parametrised N-channel round-robin merger that replaces the fixed 7-input arbiter in front of the readout FIFO.
- Collects 32-bit words from any number of FWFT source FIFOs: RX, timestamp, TLU.
- Adds per-channel enable masking, bounded burst grants, hold-for-packet semantics, a registered output stage and per-channel saturating word counters for rate monitoring.

Parameters:
- CHANNELS, 8: number of source channels (2..32).
- DATA_WIDTH, 32: width of each source word and of DATA_OUT.
- MAX_BURST, 16: hard upper bound on words per grant (1..255).
- CNT_WIDTH, 16: width of each per-channel word counter.

Ports:
- CLK  in  1  single clock for all logic.
- RST  in  1  synchronous, active-high reset.
- EN_MASK  in  CHANNELS  1 = channel may be granted.
- BURST_LEN  in  8  requested burst length. 0 is treated as 1; values above MAX_BURST are clamped to MAX_BURST.
- WRITE_REQ  in  CHANNELS  source FIFO not empty.
- HOLD_REQ  in  CHANNELS  source requests to keep the grant (packet in progress).
- DATA_IN  in  CHANNELS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]. FWFT: valid while WRITE_REQ[i]=1.
- READ_GRANT  out  CHANNELS  pop strobe to the source FIFO. Combinational, one-hot or zero.
- READY_OUT  in  1  downstream can accept a word this cycle.
- WRITE_OUT  out  1  DATA_OUT valid. Registered.
- DATA_OUT  out  DATA_WIDTH  forwarded word. Registered.
- GRANT_ID  out  clog2(CHANNELS)  currently/last granted channel. Registered.
- BUSY  out  1  state is BURST.
- CNT_CLEAR  in  1  synchronous clear of all word counters.
- WORD_CNT  out  CHANNELS*CNT_WIDTH  per-channel count of forwarded words, saturating.

Behaviour:
- Reset: state=IDLE, ptr=0, WRITE_OUT=0, DATA_OUT=0, GRANT_ID=0, BUSY=0, all WORD_CNT=0. READ_GRANT is forced to 0 while RST=1, including when RST arrives mid-burst.
- State IDLE:
  - elig = WRITE_REQ & EN_MASK.
  - If elig≠0, select the first set bit scanning ptr, ptr+1, … wrapping modulo CHANNELS.
  - Register g=selected, GRANT_ID=g, burst_cnt=0, limit=clamped BURST_LEN. Go to BURST.
  - READY_OUT is not required for selection.
- State BURST, transfer condition: READ_GRANT[g] = READY_OUT & WRITE_REQ[g] & EN_MASK[g] & ~RST.
- On a transfer:
  - DATA_OUT <= DATA_IN[g], WRITE_OUT <= 1 on the next edge (latency 1), burst_cnt+1.
  - Otherwise WRITE_OUT <= 0.
  - Word is sampled in the same cycle as the pop.
- Exit BURST to IDLE (effective next edge, ptr <= g+1 mod CHANNELS) when any of:
  - EN_MASK[g]=0;
  - HOLD_REQ[g]=0 and burst_cnt after this cycle equals limit;
  - HOLD_REQ[g]=0 and WRITE_REQ[g]=0.
- HOLD_REQ[g]=1 keeps the grant even past limit and while the source is empty. This guarantees packet contiguity. EN_MASK drop overrides HOLD_REQ.
- READY_OUT=0 in BURST: no pop, burst_cnt unchanged, grant kept. The exit rules still apply, except that the limit rule needs a transfer.
- Throughput: 1 word/cycle inside a burst; one idle arbitration cycle between grants.
- HOLD_REQ of non-granted channels is ignored.
- Fairness: after a grant to g, every other eligible channel is served before g again.
- Word counters:
  - WORD_CNT[i] increments on each READ_GRANT[i] and saturates at 2^CNT_WIDTH-1.
  - CNT_CLEAR has priority: a coincident pop is not counted (counter reads 0).
- Mask change in IDLE takes effect at the same cycle's selection.

Test Plan:
- Ch0 and ch3 each hold 5 words, BURST_LEN=2, READY_OUT=1, HOLD_REQ=0 → DATA_OUT order is ch0×2, ch3×2, ch0×2, ch3×2, ch0, ch3. One WRITE_OUT=0 gap between grants. WORD_CNT[0]=WORD_CNT[3]=5.
- Ch1 HOLD_REQ=1 with 3 words, source empty for 4 cycles, then 2 more words; ch2 also requesting; BURST_LEN=1 → all 5 ch1 words are contiguous and ch2 is not granted until HOLD_REQ[1] falls.
- READY_OUT toggled 1,0,0,1 during a burst → READ_GRANT is high only when READY_OUT=1, no words duplicated or lost, WRITE_OUT latency is 1 cycle.
- EN_MASK=8'b1111_1011 with ch2 requesting only → no grant and BUSY=0. Clear the mask bit of the granted channel mid-burst with HOLD_REQ=1 → return to IDLE next cycle.
- CNT_WIDTH=4, 20 words from ch5 → WORD_CNT[5]=15 (saturated). CNT_CLEAR asserted with a pop in the same cycle → WORD_CNT[5]=0.
- Assert RST in the 2nd cycle of a 4-word burst → READ_GRANT=0 during reset. After reset: WRITE_OUT=0, DATA_OUT=0, ptr=0, so ch0 wins the next arbitration against ch7.

Source files
------------

// File: rtl/stream_arbiter_burst.sv
// rtl/stream_arbiter_burst.sv - N-channel round-robin burst merger with hold-for-packet and word counters
module stream_arbiter_burst #(
    parameter int CHANNELS   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int CNT_WIDTH  = 16,
    localparam int IDW       = $clog2(CHANNELS)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [CHANNELS-1:0]            EN_MASK,
    input  logic [7:0]                     BURST_LEN,
    input  logic [CHANNELS-1:0]            WRITE_REQ,
    input  logic [CHANNELS-1:0]            HOLD_REQ,
    input  logic [CHANNELS*DATA_WIDTH-1:0] DATA_IN,
    output logic [CHANNELS-1:0]            READ_GRANT,
    input  logic                           READY_OUT,
    output logic                           WRITE_OUT,
    output logic [DATA_WIDTH-1:0]          DATA_OUT,
    output logic [IDW-1:0]                 GRANT_ID,
    output logic                           BUSY,
    input  logic                           CNT_CLEAR,
    output logic [CHANNELS*CNT_WIDTH-1:0]  WORD_CNT
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state;
    logic [IDW-1:0]          ptr;
    logic [IDW-1:0]          gnt;
    logic [7:0]              burst_cnt;
    logic [7:0]              limit;
    logic [7:0]              req_limit;
    logic [CHANNELS-1:0]     elig;
    logic                    sel_found;
    logic [IDW-1:0]          sel_idx;
    logic [IDW-1:0]          ptr_next;
    logic                    xfer;
    logic                    limit_hit;
    logic                    exit_burst;
    logic [DATA_WIDTH-1:0]   din [CHANNELS];
    logic [CNT_WIDTH-1:0]    cnt [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign din[i] = DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
        assign WORD_CNT[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
    end

    assign elig = WRITE_REQ & EN_MASK;

    // Rotating priority: first eligible channel at or after ptr, wrapping.
    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!sel_found && elig[idx]) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        if (BURST_LEN == 8'd0)
            req_limit = 8'd1;
        else if (int'(BURST_LEN) > MAX_BURST)
            req_limit = 8'(MAX_BURST);
        else
            req_limit = BURST_LEN;
    end

    assign ptr_next   = (gnt == IDW'(CHANNELS - 1)) ? '0 : gnt + IDW'(1);
    assign xfer       = (state == BURST) && READY_OUT && WRITE_REQ[gnt] && EN_MASK[gnt] && !RST;
    assign READ_GRANT = xfer ? ({{(CHANNELS-1){1'b0}}, 1'b1} << gnt) : '0;
    assign limit_hit  = xfer && (({1'b0, burst_cnt} + 9'd1) >= {1'b0, limit});
    // A held packet ignores the limit and empty-source rules; a mask drop always ends it.
    assign exit_burst = !EN_MASK[gnt] || (!HOLD_REQ[gnt] && (limit_hit || !WRITE_REQ[gnt]));

    assign GRANT_ID = gnt;
    assign BUSY     = (state == BURST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            burst_cnt <= '0;
            limit     <= '0;
            WRITE_OUT <= 1'b0;
            DATA_OUT  <= '0;
        end else begin
            WRITE_OUT <= xfer;
            if (xfer) DATA_OUT <= din[gnt];
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        gnt       <= sel_idx;
                        burst_cnt <= '0;
                        limit     <= req_limit;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (xfer && burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
                    if (exit_burst) begin
                        state <= IDLE;
                        ptr   <= ptr_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (RST || CNT_CLEAR)
                cnt[i] <= '0;
            else if (READ_GRANT[i] && cnt[i] != {CNT_WIDTH{1'b1}})
                cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_stream_arbiter_burst.sv
// tb/tb_stream_arbiter_burst.sv - self-checking bench for stream_arbiter_burst
module tb_stream_arbiter_burst;

    localparam int CH = 8;
    localparam int DW = 32;
    localparam int CW = 4;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [CH-1:0]   EN_MASK = '1;
    logic [7:0]      BURST_LEN = 8'd1;
    logic [CH-1:0]   WRITE_REQ = '0;
    logic [CH-1:0]   HOLD_REQ = '0;
    logic [CH*DW-1:0] DATA_IN = '0;
    logic [CH-1:0]   READ_GRANT;
    logic            READY_OUT = 1'b1;
    logic            WRITE_OUT;
    logic [DW-1:0]   DATA_OUT;
    logic [2:0]      GRANT_ID;
    logic            BUSY;
    logic            CNT_CLEAR = 1'b0;
    logic [CH*CW-1:0] WORD_CNT;

    stream_arbiter_burst #(.CHANNELS(CH), .DATA_WIDTH(DW), .MAX_BURST(16), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST), .EN_MASK(EN_MASK), .BURST_LEN(BURST_LEN),
        .WRITE_REQ(WRITE_REQ), .HOLD_REQ(HOLD_REQ), .DATA_IN(DATA_IN),
        .READ_GRANT(READ_GRANT), .READY_OUT(READY_OUT), .WRITE_OUT(WRITE_OUT),
        .DATA_OUT(DATA_OUT), .GRANT_ID(GRANT_ID), .BUSY(BUSY),
        .CNT_CLEAR(CNT_CLEAR), .WORD_CNT(WORD_CNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Source FIFO contents emulated as FWFT arrays.
    logic [31:0] mem [CH][64];
    int head [CH];
    int tail [CH];

    logic [CH-1:0] last_grant;
    int            proto_err;
    int            cyc = 0;
    logic [31:0]   obs_data [$];
    int            obs_ch [$];
    int            obs_cyc [$];
    logic [31:0]   exp_data [$];
    int            exp_ch [$];
    int            exp_n [CH];

    task automatic load(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            mem[ch][tail[ch]] = {8'(ch), 8'(tail[ch]), 16'($urandom)};
            tail[ch]++;
        end
    endtask

    // One clock: present FIFO heads, record the pop, then record the registered output.
    task automatic step();
        logic [31:0] w;
        int gi;
        w = '0;
        for (int i = 0; i < CH; i++) begin
            WRITE_REQ[i] = (tail[i] > head[i]);
            DATA_IN[i*DW +: DW] = mem[i][head[i]];
        end
        #1;
        last_grant = READ_GRANT;
        gi = -1;
        if (((last_grant & (last_grant - 8'd1)) != 0) ||
            (last_grant != 0 && (READY_OUT !== 1'b1 || RST === 1'b1)) ||
            ((last_grant & ~(WRITE_REQ & EN_MASK)) != 0))
            proto_err++;
        for (int i = 0; i < CH; i++) if (last_grant[i]) gi = i;
        if (gi >= 0) begin
            w = mem[gi][head[gi]];
            head[gi]++;
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (WRITE_OUT !== (gi >= 0)) proto_err++;
        if (gi >= 0) begin
            if (DATA_OUT !== w || GRANT_ID !== 3'(gi)) proto_err++;
            obs_data.push_back(w);
            obs_ch.push_back(gi);
            obs_cyc.push_back(cyc);
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < CH; i++) begin head[i] = 0; tail[i] = 0; end
        RST = 1'b1; HOLD_REQ = '0; CNT_CLEAR = 1'b0; READY_OUT = 1'b1; EN_MASK = '1;
        step();
        step();
        RST = 1'b0;
        obs_data.delete(); obs_ch.delete(); obs_cyc.delete();
        proto_err = 0;
    endtask

    function automatic logic drained();
        for (int i = 0; i < CH; i++) if (EN_MASK[i] && head[i] < tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until(input logic rnd, output logic timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            READY_OUT = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            if (drained() && !BUSY) begin timed_out = 1'b0; break; end
        end
        READY_OUT = 1'b1;
    endtask

    // Reference: round-robin over non-empty enabled channels, each grant takes min(limit, remaining).
    task automatic build_expected(input logic [CH-1:0] mask, input int bl, input int start);
        int rem [CH];
        int pos [CH];
        int p, lim, n, total;
        lim = (bl == 0) ? 1 : (bl > 16 ? 16 : bl);
        exp_data.delete(); exp_ch.delete();
        total = 0;
        for (int i = 0; i < CH; i++) begin
            rem[i] = mask[i] ? tail[i] - head[i] : 0;
            pos[i] = head[i];
            exp_n[i] = rem[i];
            total += rem[i];
        end
        p = start;
        while (total > 0) begin
            for (int k = 0; k < CH; k++) begin
                int c;
                c = (p + k) % CH;
                if (rem[c] > 0) begin
                    n = (rem[c] < lim) ? rem[c] : lim;
                    for (int j = 0; j < n; j++) begin
                        exp_data.push_back(mem[c][pos[c]]);
                        exp_ch.push_back(c);
                        pos[c]++;
                    end
                    rem[c] -= n;
                    total -= n;
                    p = (c + 1) % CH;
                    break;
                end
            end
        end
    endtask

    function automatic int seq_mismatch();
        if (obs_data.size() != exp_data.size()) return -2;
        for (int k = 0; k < obs_data.size(); k++)
            if (obs_data[k] !== exp_data[k] || obs_ch[k] != exp_ch[k]) return k;
        return -1;
    endfunction

    task automatic test_reset();
        int sm;
        load(3, 2);
        RST = 1'b1;
        step();
        step();
        n_checks++;
        if (last_grant !== 8'h00 || WRITE_OUT !== 1'b0 || DATA_OUT !== 32'h0 || GRANT_ID !== 3'd0 || BUSY !== 1'b0) begin
            $display("FAIL reset_outputs: grant=%h wo=%b data=%h gid=%0d busy=%b expected all zero",
                     last_grant, WRITE_OUT, DATA_OUT, GRANT_ID, BUSY);
        end else n_pass++;
        n_checks++;
        if (WORD_CNT !== '0) $display("FAIL reset_counters: got %h expected 0", WORD_CNT);
        else n_pass++;
        sm = 0;
    endtask

    task automatic test_round_robin();
        logic to;
        int sm, gap_bad;
        do_reset();
        BURST_LEN = 8'd2;
        load(0, 5);
        load(3, 5);
        build_expected(8'hFF, 2, 0);
        run_until(1'b0, to);
        n_checks++;
        if (to) $display("FAIL rr_timeout: drain not reached within budget");
        else n_pass++;
        sm = seq_mismatch();
        n_checks++;
        if (sm != -1) $display("FAIL rr_order: first mismatch at %0d (obs %0d words, expected %0d)", sm, obs_data.size(), exp_data.size());
        else n_pass++;
        n_checks++;
        if (proto_err != 0) $display("FAIL rr_protocol: %0d violations expected 0", proto_err);
        else n_pass++;
        n_checks++;
        if (WORD_CNT[0 +: CW] !== 4'd5 || WORD_CNT[3*CW +: CW] !== 4'd5)
            $display("FAIL rr_counts: ch0=%0d ch3=%0d expected 5 and 5", WORD_CNT[0 +: CW], WORD_CNT[3*CW +: CW]);
        else n_pass++;
        gap_bad = 0;
        for (int k = 1; k < obs_ch.size(); k++) begin
            if (obs_ch[k] != obs_ch[k-1] && obs_cyc[k] - obs_cyc[k-1] < 2) gap_bad++;
        end
        n_checks++;
        if (gap_bad != 0 || obs_cyc.size() < 2 || obs_cyc[1] - obs_cyc[0] != 1)
            $display("FAIL rr_gaps: %0d grant changes without idle cycle, expected 0 and back-to-back words in burst", gap_bad);
        else n_pass++;
    endtask

    task automatic test_random();
        logic to;
        logic [CH-1:0] mask;
        int bl, sm, cnt_bad;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            mask = 8'($urandom_range(1, 255));
            bl = (it == 0) ? 0 : (it == 1) ? 200 : $urandom_range(1, 20);
            EN_MASK = mask;
            BURST_LEN = 8'(bl);
            for (int i = 0; i < CH; i++) load(i, $urandom_range(0, 12));
            build_expected(mask, bl, 0);
            run_until(1'b1, to);
            sm = seq_mismatch();
            n_checks++;
            if (to || sm != -1 || proto_err != 0)
                $display("FAIL random_%0d: timeout=%b mismatch_at=%0d proto=%0d expected 0/-1/0 (mask=%h bl=%0d)", it, to, sm, proto_err, mask, bl);
            else n_pass++;
            cnt_bad = 0;
            for (int i = 0; i < CH; i++) begin
                if (int'(WORD_CNT[i*CW +: CW]) != ((exp_n[i] > 15) ? 15 : exp_n[i])) cnt_bad++;
            end
            n_checks++;
            if (cnt_bad != 0) $display("FAIL random_counts_%0d: %0d channels with wrong count, expected 0", it, cnt_bad);
            else n_pass++;
        end
        EN_MASK = '1;
    endtask

    task automatic test_hold();
        int empty_cycles, sm;
        logic added, ch2_early, busy_gap_ok;
        do_reset();
        BURST_LEN = 8'd1;
        HOLD_REQ = 8'h02;
        load(1, 3);
        load(2, 2);
        empty_cycles = 0; added = 1'b0; ch2_early = 1'b0; busy_gap_ok = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step();
            if (last_grant[2] && HOLD_REQ[1]) ch2_early = 1'b1;
            if (!added && head[1] == 3) begin
                empty_cycles++;
                if (!BUSY) busy_gap_ok = 1'b0;
                if (empty_cycles == 4) begin load(1, 2); added = 1'b1; end
            end
            if (added && head[1] == 5) HOLD_REQ[1] = 1'b0;
            if (head[2] == 2 && !BUSY) break;
        end
        exp_data.delete(); exp_ch.delete();
        for (int k = 0; k < 5; k++) begin exp_data.push_back(mem[1][k]); exp_ch.push_back(1); end
        for (int k = 0; k < 2; k++) begin exp_data.push_back(mem[2][k]); exp_ch.push_back(2); end
        sm = seq_mismatch();
        n_checks++;
        if (sm != -1) $display("FAIL hold_order: mismatch at %0d (obs %0d words, expected 7)", sm, obs_data.size());
        else n_pass++;
        n_checks++;
        if (ch2_early || !busy_gap_ok) $display("FAIL hold_grant: ch2_early=%b busy_during_gap=%b expected 0 and 1", ch2_early, busy_gap_ok);
        else n_pass++;
        n_checks++;
        if (proto_err != 0) $display("FAIL hold_protocol: %0d violations expected 0", proto_err);
        else n_pass++;
        HOLD_REQ = '0;
    endtask

    task automatic test_ready_toggle();
        logic [7:0] pat;
        int sm;
        do_reset();
        BURST_LEN = 8'd4;
        load(4, 4);
        step();
        pat = 8'b1111_1001;
        for (int c = 0; c < 8; c++) begin
            READY_OUT = pat[c];
            step();
            if (!pat[c]) begin
                n_checks++;
                if (last_grant !== 8'h00) $display("FAIL ready_low_grant: got %h expected 00", last_grant);
                else n_pass++;
            end
        end
        READY_OUT = 1'b1;
        exp_data.delete(); exp_ch.delete();
        for (int k = 0; k < 4; k++) begin exp_data.push_back(mem[4][k]); exp_ch.push_back(4); end
        sm = seq_mismatch();
        n_checks++;
        if (sm != -1 || proto_err != 0) $display("FAIL ready_words: mismatch_at=%0d proto=%0d expected -1 and 0", sm, proto_err);
        else n_pass++;
    endtask

    task automatic test_mask();
        logic any_grant;
        do_reset();
        EN_MASK = 8'hFB;
        load(2, 3);
        any_grant = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (last_grant != 0) any_grant = 1'b1;
        end
        n_checks++;
        if (BUSY !== 1'b0 || any_grant) $display("FAIL mask_blocked: busy=%b grant_seen=%b expected 0 and 0", BUSY, any_grant);
        else n_pass++;
        head[2] = tail[2];
        EN_MASK = 8'hFF;
        HOLD_REQ = 8'h40;
        BURST_LEN = 8'd16;
        load(6, 10);
        step();
        step();
        step();
        EN_MASK = 8'hBF;
        step();
        n_checks++;
        if (last_grant !== 8'h00 || BUSY !== 1'b0) $display("FAIL mask_drop: grant=%h busy=%b expected 00 and 0", last_grant, BUSY);
        else n_pass++;
        step();
        n_checks++;
        if (BUSY !== 1'b0 || head[6] != 2) $display("FAIL mask_idle: busy=%b popped=%0d expected 0 and 2", BUSY, head[6]);
        else n_pass++;
        EN_MASK = 8'hFF;
        HOLD_REQ = '0;
    endtask

    task automatic test_saturate();
        logic to;
        do_reset();
        BURST_LEN = 8'd16;
        load(5, 20);
        run_until(1'b0, to);
        n_checks++;
        if (to || obs_data.size() != 20 || WORD_CNT[5*CW +: CW] !== 4'd15)
            $display("FAIL sat_count: timeout=%b words=%0d cnt=%0d expected 0, 20, 15", to, obs_data.size(), WORD_CNT[5*CW +: CW]);
        else n_pass++;
        load(5, 3);
        for (int c = 0; c < 5 && !BUSY; c++) step();
        CNT_CLEAR = 1'b1;
        step();
        CNT_CLEAR = 1'b0;
        n_checks++;
        if (last_grant !== 8'h20 || WORD_CNT[5*CW +: CW] !== 4'd0)
            $display("FAIL clear_priority: grant=%h cnt=%0d expected 20 and 0", last_grant, WORD_CNT[5*CW +: CW]);
        else n_pass++;
        step();
        n_checks++;
        if (WORD_CNT[5*CW +: CW] !== 4'd1) $display("FAIL count_after_clear: got %0d expected 1", WORD_CNT[5*CW +: CW]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        logic to;
        do_reset();
        BURST_LEN = 8'd4;
        load(7, 4);
        step();
        step();
        RST = 1'b1;
        step();
        n_checks++;
        if (last_grant !== 8'h00) $display("FAIL reset_grant: got %h expected 00", last_grant);
        else n_pass++;
        n_checks++;
        if (WRITE_OUT !== 1'b0 || DATA_OUT !== 32'h0 || BUSY !== 1'b0 || GRANT_ID !== 3'd0)
            $display("FAIL reset_mid_state: wo=%b data=%h busy=%b gid=%0d expected 0", WRITE_OUT, DATA_OUT, BUSY, GRANT_ID);
        else n_pass++;
        load(0, 2);
        step();
        RST = 1'b0;
        obs_data.delete(); obs_ch.delete(); obs_cyc.delete();
        step();
        n_checks++;
        if (GRANT_ID !== 3'd0 || BUSY !== 1'b1) $display("FAIL reset_ptr: gid=%0d busy=%b expected 0 and 1", GRANT_ID, BUSY);
        else n_pass++;
        run_until(1'b0, to);
        n_checks++;
        if (to || obs_ch.size() != 5 || obs_ch[0] != 0) $display("FAIL reset_first_winner: timeout=%b words=%0d expected 0 and 5 with ch0 first", to, obs_ch.size());
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin
            head[i] = 0; tail[i] = 0;
            for (int k = 0; k < 64; k++) mem[i][k] = '0;
        end
        proto_err = 0;
        last_grant = '0;
        test_reset();
        test_round_robin();
        test_random();
        test_hold();
        test_ready_toggle();
        test_mask();
        test_saturate();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
